// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control for the 5-stage Y86-64 core: stall/bubble steering,
// run-state sequencing (IDLE/RUN/HALTED), final status latch and perf counters.
module pipe_hazard_ctrl #(
  parameter int          CNT_W = 32,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             cpu_halted,
  output logic [3:0]       stat_out,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] S_AOK    = 4'h1;
  localparam logic [3:0] S_HLT    = 4'h2;
  localparam logic [3:0] S_ADR    = 4'h3;
  localparam logic [3:0] S_INS    = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  function automatic logic is_exc(input logic [3:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e           state_q;
  logic             halted_q;
  logic [3:0]       stat_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] mispred_q;
  logic [CNT_W-1:0] cycle_d;
  logic [CNT_W-1:0] stall_d;
  logic [CNT_W-1:0] mispred_d;

  logic loaduse_s;
  logic ret_s;
  logic mispred_s;
  logic m_exc_s;
  logic w_exc_s;
  logic f_stall_s;
  logic d_stall_s;
  logic d_bubble_s;
  logic e_bubble_s;
  logic m_bubble_s;
  logic w_stall_s;

  // Raw hazard detection from the current stage fields
  always_comb begin
    loaduse_s = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_s     = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispred_s = (E_icode == I_JXX) && !e_Cnd;
    m_exc_s   = is_exc(m_stat);
    w_exc_s   = is_exc(W_stat);
  end

  // Stall/bubble steering per run state; load-use stall outranks the ret bubble
  always_comb begin
    f_stall_s  = 1'b1;
    d_stall_s  = 1'b0;
    d_bubble_s = 1'b1;
    e_bubble_s = 1'b1;
    m_bubble_s = 1'b1;
    w_stall_s  = 1'b0;
    case (state_q)
      ST_RUN: begin
        f_stall_s  = loaduse_s | ret_s;
        d_stall_s  = loaduse_s;
        d_bubble_s = mispred_s | (ret_s & ~loaduse_s);
        e_bubble_s = mispred_s | loaduse_s;
        m_bubble_s = m_exc_s | w_exc_s;
        w_stall_s  = w_exc_s;
      end
      ST_HALTED: begin
        f_stall_s  = 1'b1;
        d_stall_s  = 1'b1;
        d_bubble_s = 1'b0;
        e_bubble_s = 1'b1;
        m_bubble_s = 1'b1;
        w_stall_s  = 1'b1;
      end
      ST_IDLE: begin
        f_stall_s  = 1'b1;
        d_stall_s  = 1'b0;
        d_bubble_s = 1'b1;
        e_bubble_s = 1'b1;
        m_bubble_s = 1'b1;
        w_stall_s  = 1'b0;
      end
      default: begin
        f_stall_s  = 1'b1;
        d_stall_s  = 1'b0;
        d_bubble_s = 1'b1;
        e_bubble_s = 1'b1;
        m_bubble_s = 1'b1;
        w_stall_s  = 1'b0;
      end
    endcase
  end

  // Saturating next values for the performance counters
  always_comb begin
    cycle_d   = sat_inc(cycle_q);
    if (f_stall_s) begin
      stall_d = sat_inc(stall_q);
    end else begin
      stall_d = stall_q;
    end
    if (mispred_s) begin
      mispred_d = sat_inc(mispred_q);
    end else begin
      mispred_d = mispred_q;
    end
  end

  // Run-state FSM with status latch and counters; reset dominates everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      halted_q  <= 1'b0;
      stat_q    <= S_AOK;
      cycle_q   <= {CNT_W{1'b0}};
      stall_q   <= {CNT_W{1'b0}};
      mispred_q <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          cycle_q   <= cycle_d;
          stall_q   <= stall_d;
          mispred_q <= mispred_d;
          if (w_exc_s) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
            stat_q   <= W_stat;
          end
        end
        ST_HALTED: begin
          state_q  <= ST_HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign F_stall     = f_stall_s;
  assign D_stall     = d_stall_s;
  assign D_bubble    = d_bubble_s;
  assign E_bubble    = e_bubble_s;
  assign M_bubble    = m_bubble_s;
  assign W_stall     = w_stall_s;
  assign cpu_halted  = halted_q;
  assign stat_out    = stat_q;
  assign cycle_cnt   = cycle_q;
  assign stall_cnt   = stall_q;
  assign mispred_cnt = mispred_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline control unit for the 5-stage Y86-64 core. Each cycle it examines decode/execute/memory/writeback stage fields and drives stall/bubble controls for the F, D, E, M and W pipeline registers, covering load-use, ret, branch-mispredict and exception hazards. It also runs a run-state FSM (IDLE/RUN/HALTED) that gates the pipeline from start to halt, latches the final status, and keeps saturating performance counters.

Parameters:
CNT_W, 32, width of the cycle/stall/mispredict counters
RNONE, 4'hF, register ID meaning "no register"

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; IDLE -> RUN
D_icode  input  4  icode in D register
d_srcA  input  4  srcA computed in decode
d_srcB  input  4  srcB computed in decode
E_icode  input  4  icode in E register
E_dstM  input  4  dstM in E register
e_Cnd  input  1  condition result in execute
M_icode  input  4  icode in M register
m_stat  input  4  status out of memory stage
W_stat  input  4  status in W register
F_stall  output  1  hold F register
D_stall  output  1  hold D register
D_bubble  output  1  load nop into D
E_bubble  output  1  load nop into E
M_bubble  output  1  load nop into M
W_stall  output  1  hold W register
cpu_halted  output  1  registered; 1 in HALTED
stat_out  output  4  registered final status
cycle_cnt  output  CNT_W  RUN cycles
stall_cnt  output  CNT_W  RUN cycles with F_stall=1
mispred_cnt  output  CNT_W  RUN cycles with mispredict

Behaviour:
- Encodings: JXX=7, RET=9, MRMOVQ=5, POPQ=B; stat AOK=1, HLT=2, ADR=3, INS=4. exc(s) = s in {2,3,4}; all other values non-exceptional.
- Hazard terms (combinational):
  - loaduse = E_icode in {5,B} && E_dstM != RNONE && (E_dstM==d_srcA || E_dstM==d_srcB)
  - ret_p = 9 in {D_icode, E_icode, M_icode}
  - mispred = E_icode==7 && !e_Cnd
  - m_exc = exc(m_stat); w_exc = exc(W_stat)
- Stall/bubble controls are combinational from state and inputs; no added latency.
- RUN:
  - F_stall = loaduse | ret_p
  - D_stall = loaduse
  - D_bubble = mispred | (ret_p & !loaduse); stall wins, so D_stall and D_bubble are never both 1
  - E_bubble = mispred | loaduse
  - M_bubble = m_exc | w_exc
  - W_stall = w_exc
- IDLE (reset state):
  - F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, D_stall=0, W_stall=0
  - start=1 -> RUN next cycle; start is ignored in RUN/HALTED.
- RUN -> HALTED:
  - Transition happens on the clock edge where w_exc=1; stat_out <= W_stat on that same edge.
  - The cycle w_exc is seen still uses the RUN equations.
- HALTED:
  - F_stall=1, D_stall=1, W_stall=1, E_bubble=1, M_bubble=1, D_bubble=0
  - Only rst_n exits.
- Counters, incremented only in RUN, each saturating at all-ones (no wrap):
  - cycle_cnt +1 every cycle
  - stall_cnt +1 when F_stall=1
  - mispred_cnt +1 when mispred=1
- Reset (rst_n=0 at a rising edge, any state including mid-RUN): state=IDLE, counters=0, stat_out=1, cpu_halted=0. Reset dominates start and w_exc in the same cycle.
- cpu_halted = (state==HALTED), registered.

Test Plan:
- Reset then start: rst_n=0 for 2 cycles, start pulse -> IDLE outputs (F_stall=1, D_bubble=1), then RUN with all controls 0; stat_out=1, counters=0.
- Load-use: E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; same case with E_dstM=F -> all 0.
- Ret: D_icode=9 for 1 cycle, then E_icode=9, then M_icode=9 -> F_stall=1 and D_bubble=1 for 3 cycles; stall_cnt +3. Ret plus load-use -> D_stall=1, D_bubble=0.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, mispred_cnt +1; e_Cnd=1 -> no bubbles.
- Halt: m_stat=2 -> M_bubble=1; next cycle W_stat=2 -> W_stall=1, then HALTED: cpu_halted=1, stat_out=2; start is ignored; rst_n=0 returns to IDLE.
- Saturation: with CNT_W=4, run 20 cycles -> cycle_cnt holds at 15.
